// File: rtl/pixel_buffer_pkg.sv
// pixel_buffer_pkg: shared types and defaults for the pixel buffer responder
package pixel_buffer_pkg;
  typedef enum logic {WRITE_PRIO, READ_GRANT} arb_state_e;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0800_0000;
  localparam int DEF_DEPTH = 76800;
endpackage

// File: rtl/pixel_ram_sp.sv
// pixel_ram_sp: single-port byte-enabled synchronous frame RAM with 1-cycle read
module pixel_ram_sp
  import pixel_buffer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = 17
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [1:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);
  logic [1:0][7:0] mem [DEPTH];
  logic in_range;
  assign in_range = 32'(addr_i) < 32'(DEPTH);
  // lane-masked write plus registered read of the addressed word
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 2; b++)
      if (we_i && in_range && be_i[b]) mem[addr_i][b] <= wdata_i[8*b +: 8];
    rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/pixel_buffer_responder.sv
// pixel_buffer_responder: Avalon-MM pixel read responder sharing one frame RAM port with CPU writes
module pixel_buffer_responder
  import pixel_buffer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter int          DEPTH        = DEF_DEPTH,
  parameter int          AW           = 17,
  parameter int          READ_LATENCY = 2,
  parameter int          WR_BURST_MAX = 8
) (
  input  logic          sys_clk_clk,
  input  logic          sys_reset_reset,
  input  logic [31:0]   pix_address,
  input  logic          pix_read,
  input  logic          pix_lock,
  output logic          pix_waitrequest,
  output logic [15:0]   pix_readdata,
  output logic          pix_readdatavalid,
  input  logic [AW-1:0] wr_address,
  input  logic [15:0]   wr_writedata,
  input  logic [1:0]    wr_byteenable,
  input  logic          wr_write,
  output logic          wr_waitrequest
);
  localparam int CW = $clog2(WR_BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WR_BURST_MAX);
  arb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] off, half;
  logic [AW-1:0] idx;
  logic oor, rd_acc, wr_gnt;
  rgb565_t ram_rdata, last_d;
  logic [READ_LATENCY-1:0] v_q, z_q;
  logic [15:0] hold_q;
  logic unused_sig;
  assign off = pix_address - BASE_ADDR;
  assign half = {1'b0, off[31:1]};
  assign idx = half[AW-1:0];
  assign oor = (pix_address < BASE_ADDR) || (half >= 32'(DEPTH));
  assign unused_sig = ^{pix_lock, off[0]};
  assign rd_acc = pix_read && !pix_waitrequest;
  assign wr_gnt = wr_write && !wr_waitrequest;
  // arbiter state and starvation counter
  always_ff @(posedge sys_clk_clk) begin
    if (sys_reset_reset) begin
      state_q <= WRITE_PRIO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // writes win the RAM port; an in-range read starved for WR_BURST_MAX writes gets one forced slot
  always_comb begin
    state_d = WRITE_PRIO;
    cnt_d = '0;
    pix_waitrequest = 1'b0;
    wr_waitrequest = 1'b0;
    cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    if (state_q == READ_GRANT) wr_waitrequest = 1'b1;
    else if (wr_write) begin
      pix_waitrequest = !oor;
      cnt_d = cnt_inc;
      state_d = (pix_read && !oor && cnt_inc == CNT_MAX) ? READ_GRANT : WRITE_PRIO;
    end
    if (sys_reset_reset) begin
      pix_waitrequest = 1'b1;
      wr_waitrequest = 1'b1;
    end
  end
  pixel_ram_sp #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (sys_clk_clk),
    .we_i    (wr_gnt),
    .be_i    (wr_byteenable),
    .addr_i  (wr_gnt ? wr_address : idx),
    .wdata_i (wr_writedata),
    .rdata_o (ram_rdata)
  );
  if (READ_LATENCY == 1) begin : g_lat1
    assign last_d = ram_rdata;
  end else begin : g_latn
    rgb565_t dq [READ_LATENCY-1];
    // data stages behind the RAM output register
    always_ff @(posedge sys_clk_clk) begin
      dq[0] <= ram_rdata;
      for (int i = 1; i < READ_LATENCY - 1; i++) dq[i] <= dq[i-1];
    end
    assign last_d = dq[READ_LATENCY-2];
  end
  // valid and zero-flag shift chain aligned with the data stages
  always_ff @(posedge sys_clk_clk) begin
    if (sys_reset_reset) begin
      v_q <= '0;
      z_q <= '0;
    end else begin
      v_q <= READ_LATENCY'({v_q, rd_acc});
      z_q <= READ_LATENCY'({z_q, oor});
    end
  end
  assign pix_readdatavalid = v_q[READ_LATENCY-1];
  assign pix_readdata = !pix_readdatavalid ? hold_q : z_q[READ_LATENCY-1] ? 16'h0000 : last_d;
  // keep the last delivered pixel on the bus between responses
  always_ff @(posedge sys_clk_clk) begin
    if (sys_reset_reset) hold_q <= '0;
    else if (pix_readdatavalid) hold_q <= pix_readdata;
  end
endmodule

// File: doc/pixel_buffer_responder.md
Name: pixel_buffer_responder

Overview:
- Avalon-MM read responder at the far end of the VGA pixel DMA master.
- Serves 16-bit RGB565 pixels from an on-chip single-port frame RAM. A CPU-side write port fills that RAM.
- Sits between the system interconnect and the VGA subsystem's pixel_dma_master. It replaces external SDRAM for small frame buffers.
- Arbitrates the single RAM port between DMA reads and CPU writes, with a starvation guard.

Parameters:
- BASE_ADDR, 32'h0800_0000, byte base address of the frame buffer on the DMA bus.
- DEPTH, 76800, pixel count (320x240).
- AW, 17, RAM index width, clog2(DEPTH).
- READ_LATENCY, 2, cycles from read accept to readdatavalid; legal range 1..4.
- WR_BURST_MAX, 8, consecutive write-priority cycles before one read slot is forced.

Ports:
- sys_clk_clk  in  1  system clock.
- sys_reset_reset  in  1  synchronous active-high reset.
- pix_address  in  32  byte address from the pixel DMA master.
- pix_read  in  1  read request.
- pix_lock  in  1  bus lock; accepted and ignored.
- pix_waitrequest  out  1  stall; request held by the master while high.
- pix_readdata  out  16  pixel data.
- pix_readdatavalid  out  1  pix_readdata valid this cycle.
- wr_address  in  AW  pixel index for a CPU write.
- wr_writedata  in  16  pixel value.
- wr_byteenable  in  2  byte lanes.
- wr_write  in  1  write request.
- wr_waitrequest  out  1  write stall.

Behaviour:
- Interface (already decided): one clock, sys_clk_clk. Reset sys_reset_reset is synchronous and active-high.
- Reset values:
  - pix_waitrequest=1 and wr_waitrequest=1 while reset is high.
  - pix_readdatavalid=0, pix_readdata=0.
  - Read pipeline valid bits cleared; reads in flight are dropped and never produce a readdatavalid.
  - Arbiter state = WRITE_PRIO, starvation counter = 0.
  - RAM contents are not reset.
- Address decode:
  - idx = (pix_address - BASE_ADDR) >> 1, truncated to AW bits. Bit 0 of the address is ignored.
  - Out of range means pix_address < BASE_ADDR or idx >= DEPTH. An out-of-range read is still accepted and returns 16'h0000 with normal latency; the RAM is not accessed.
- Arbiter FSM, evaluated each cycle:
  - WRITE_PRIO:
    - If wr_write and pix_read: grant the write. wr_waitrequest=0, pix_waitrequest=1, count++.
    - If count reaches WR_BURST_MAX: go to READ_GRANT.
    - Write only: grant it, count++.
    - Read only: grant it, count=0.
    - Neither: count=0.
  - READ_GRANT (exactly one cycle):
    - pix_waitrequest=0, wr_waitrequest=1. A read is granted if present.
    - Then count=0 and return to WRITE_PRIO.
    - An out-of-range read is never stalled by a write; it bypasses the RAM.
- Write: on grant, RAM[wr_address] lanes are updated per wr_byteenable. wr_byteenable=2'b00 still consumes the slot.
- Read acceptance: pix_read && !pix_waitrequest.
- Read pipeline:
  - Fixed READ_LATENCY stages, each holding a valid bit, a zero_flag and data.
  - Stage 1 captures the RAM synchronous output. Later stages are plain registers.
  - pix_readdatavalid = last-stage valid. pix_readdata = data, or 0 when zero_flag is set; it is held at its last value when not valid.
  - One read may be accepted per cycle. Responses are strictly in order. There is no outstanding limit and no response backpressure.
- Read-after-write to the same idx, write granted in cycle N: a read accepted in cycle N+1 or later returns the new value. A read and a write are never granted in the same cycle.
- Continuous reads with no writes: full throughput, pix_waitrequest stays low.

Decomposition:
- Package pixel_buffer_pkg:
  - arbiter state enum {WRITE_PRIO, READ_GRANT}.
  - RGB565 pixel typedef.
  - Default BASE_ADDR and DEPTH constants.
- Sub-module pixel_ram_sp: single-port byte-enabled synchronous RAM with 1-cycle read. Infers block RAM.
- The arbiter and the read pipeline stay in the top level.

Test Plan:
- Reset mid-read: assert sys_reset_reset during READ_LATENCY-1 in-flight reads -> no pix_readdatavalid afterwards; both waitrequests are 1 during reset and 0 on the first idle cycle after.
- Basic read: CPU writes 16'hF800 at idx 5. DMA reads 32'h0800_000A -> pix_readdatavalid exactly READ_LATENCY cycles after accept, pix_readdata=16'hF800.
- Streaming: 100 back-to-back reads of idx 0..99 preloaded with value=idx -> 100 consecutive valid cycles, data 0..99 in order, pix_waitrequest never high.
- Starvation guard: wr_write held high continuously, pix_read held high -> exactly 1 read accepted per WR_BURST_MAX+1 cycles (one per 9 at default); wr_waitrequest=1 in that read cycle only.
- Out-of-range: read 32'h0802_5800 (idx 76800) and 32'h07FF_FFFE -> both return 16'h0000 with normal latency, no stall even while writes are pending.
- Byte enables: idx 7 holds 16'h1234; write 16'hABCD with wr_byteenable=2'b10, then read idx 7 -> 16'hAB34.
